// File: rtl/cache_pkg.sv
// Shared widths, FSM state type and address field helpers for cache_ctrl.
// Word address layout: tag[16:14] | index[13:4] | offset[3:0].
package cache_pkg;

  localparam int ADDR_W   = 17;
  localparam int DATA_W   = 32;
  localparam int INDEX_W  = 10;
  localparam int OFFSET_W = 4;
  localparam int TAG_W    = 3;
  localparam int LINES    = 1 << INDEX_W;
  localparam int RAM_AW   = INDEX_W + OFFSET_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL_REQ,
    REFILL,
    WRITE_MEM,
    RESP
  } state_e;

  function automatic logic [TAG_W-1:0] tag_of(
    input logic [ADDR_W-1:0] a
  );
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] index_of(
    input logic [ADDR_W-1:0] a
  );
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] offset_of(
    input logic [ADDR_W-1:0] a
  );
    return a[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/cache_data_ram.sv
// Line data store: 16384 x DATA_W single-port RAM, registered read.
// Ports: clk, we, addr {index,offset}, wdata in; rdata out (1-cycle).
module cache_data_ram
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [1 << RAM_AW];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-through cache sequencer: CPU port, tag/valid
// state, 16-beat refill and word write-through. Optional CACHE_CTRL_STATS_EN
// adds saturating hit_count/miss_count outputs.
module cache_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_resp_rdata,
  output logic              cpu_resp_hit,
`ifdef CACHE_CTRL_STATS_EN
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
`endif
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [OFFSET_W-1:0] beat_q, beat_d;
  logic [DATA_W-1:0]   crit_q, crit_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q [LINES];
  logic                tag_we;

  logic                rdy_q, rdy_d;
  logic                rv_q, rv_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                hit_q, hit_d;
  logic                mv_q, mv_d;
  logic                mwe_q, mwe_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [DATA_W-1:0]   mwdata_q, mwdata_d;

  logic                ram_we;
  logic [RAM_AW-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_rdata;
  logic                hit;

  cache_data_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign hit = valid_q[index_of(addr_q)] &&
               (tag_q[index_of(addr_q)] == tag_of(addr_q));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    beat_d    = beat_q;
    crit_d    = crit_q;
    valid_d   = valid_q;
    tag_we    = 1'b0;
    rv_d      = 1'b0;
    rdata_d   = rdata_q;
    hit_d     = hit_q;
    mv_d      = mv_q;
    mwe_d     = mwe_q;
    maddr_d   = maddr_q;
    mwdata_d  = mwdata_q;
    ram_we    = 1'b0;
    ram_addr  = {index_of(addr_q), offset_of(addr_q)};
    ram_wdata = wdata_q;
    unique case (state_q)
      IDLE: begin
        // Read starts on the request address so data lands in LOOKUP.
        ram_addr = {index_of(cpu_req_addr), offset_of(cpu_req_addr)};
        if (cpu_req_valid) begin
          addr_d  = cpu_req_addr;
          we_d    = cpu_req_we;
          wdata_d = cpu_req_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        hit_d = hit;
        if (we_q) begin
          ram_we   = hit;
          mv_d     = 1'b1;
          mwe_d    = 1'b1;
          maddr_d  = addr_q;
          mwdata_d = wdata_q;
          state_d  = WRITE_MEM;
        end else if (hit) begin
          rv_d    = 1'b1;
          rdata_d = ram_rdata;
          state_d = RESP;
        end else begin
          mv_d    = 1'b1;
          mwe_d   = 1'b0;
          maddr_d = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          state_d = REFILL_REQ;
        end
      end
      REFILL_REQ: begin
        if (mem_req_ready) begin
          mv_d    = 1'b0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        ram_addr  = {index_of(addr_q), beat_q};
        ram_wdata = mem_rdata;
        if (mem_rvalid) begin
          ram_we = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == offset_of(addr_q)) crit_d = mem_rdata;
          if (beat_q == '1) begin
            valid_d[index_of(addr_q)] = 1'b1;
            tag_we  = 1'b1;
            rv_d    = 1'b1;
            // Critical word may be the final beat itself.
            rdata_d = (beat_q == offset_of(addr_q)) ? mem_rdata : crit_q;
            state_d = RESP;
          end
        end
      end
      WRITE_MEM: begin
        if (mem_req_ready) begin
          mv_d    = 1'b0;
          rv_d    = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      beat_q   <= '0;
      crit_q   <= '0;
      valid_q  <= '0;
      rdy_q    <= 1'b1;
      rv_q     <= 1'b0;
      rdata_q  <= '0;
      hit_q    <= 1'b0;
      mv_q     <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      beat_q   <= beat_d;
      crit_q   <= crit_d;
      valid_q  <= valid_d;
      rdy_q    <= rdy_d;
      rv_q     <= rv_d;
      rdata_q  <= rdata_d;
      hit_q    <= hit_d;
      mv_q     <= mv_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  // Tags need no reset; valid_q gates every use.
  always_ff @(posedge clk) begin
    if (tag_we) tag_q[index_of(addr_q)] <= tag_of(addr_q);
  end

  assign cpu_req_ready  = rdy_q;
  assign cpu_resp_valid = rv_q;
  assign cpu_resp_rdata = rdata_q;
  assign cpu_resp_hit   = hit_q;
  assign mem_req_valid  = mv_q;
  assign mem_req_we     = mwe_q;
  assign mem_req_addr   = maddr_q;
  assign mem_req_wdata  = mwdata_q;

`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] hcnt_q, hcnt_d;
  logic [31:0] mcnt_q, mcnt_d;

  always_comb begin
    hcnt_d = hcnt_q;
    mcnt_d = mcnt_q;
    if (state_q == LOOKUP) begin
      if (hit) begin
        if (hcnt_q != '1) hcnt_d = hcnt_q + 32'd1;
      end else begin
        if (mcnt_q != '1) mcnt_d = mcnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign hit_count  = hcnt_q;
  assign miss_count = mcnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: main-memory model plus a
// tag/valid reference; directed plan followed by random traffic.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_req_we;
  logic [16:0] cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic        cpu_resp_hit;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [16:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  cache_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_we     (cpu_req_we),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_rdata (cpu_resp_rdata),
    .cpu_resp_hit   (cpu_resp_hit),
`ifdef CACHE_CTRL_STATS_EN
    .hit_count      (hit_count),
    .miss_count     (miss_count),
`endif
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  // Main memory contents and the reference view of tag/valid state.
  logic [31:0] mm [131072];
  bit          rv [1024];
  logic [2:0]  rt [1024];

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] last_rdata;
  logic        last_hit;
  logic [16:0] la;
  logic        lw;
  logic [31:0] ld;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic run_req(input bit we, input logic [16:0] a,
                         input logic [31:0] d, input int rdy_wait,
                         input int gap);
    logic [9:0]  idx;
    logic [2:0]  tg;
    bit          exp_hit, accepted, done, pv;
    int          cyc, waited, beats, nreq, last_act;
    logic [16:0] pa;
    logic        pw;
    logic [31:0] pd;
    logic [3:0]  bb;
    idx = a[13:4];
    tg  = a[16:14];
    exp_hit = rv[idx] && (rt[idx] == tg);
    @(negedge clk);
    chk("req_ready", 32'(cpu_req_ready), 32'd1);
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = a;
    cpu_req_wdata = d;
    @(negedge clk);
    // Scramble inputs: the request must already be captured.
    cpu_req_valid = 1'b0;
    cpu_req_we    = 1'($urandom);
    cpu_req_addr  = 17'($urandom);
    cpu_req_wdata = $urandom;
    cyc = 1; waited = 0; beats = 0; nreq = 0; last_act = 0;
    accepted = 0; done = 0; pv = 0;
    pa = '0; pw = 1'b0; pd = '0;
    while (!done && cyc < 300) begin
      mem_rvalid    = 1'b0;
      mem_rdata     = $urandom;
      mem_req_ready = 1'b0;
      if (cpu_resp_valid) begin
        done = 1;
      end else begin
        if (mem_req_valid && accepted) begin
          nreq++;
        end else if (mem_req_valid) begin
          if (pv) begin
            chk("mreq_hold_addr", 32'({mem_req_we, mem_req_addr}),
                32'({pw, pa}));
            chk("mreq_hold_wdata", mem_req_wdata, pd);
          end
          pv = 1; pa = mem_req_addr; pw = mem_req_we;
          pd = mem_req_wdata;
          if (waited >= rdy_wait) begin
            mem_req_ready = 1'b1;
            accepted = 1; nreq++;
            la = mem_req_addr; lw = mem_req_we; ld = mem_req_wdata;
            last_act = cyc;
          end else begin
            waited++;
            // Beats while no burst is granted must be ignored.
            mem_rvalid = 1'($urandom);
          end
        end else if (accepted && !lw && beats < 16) begin
          if (int'($urandom_range(99)) >= gap) begin
            bb = 4'(beats);
            mem_rvalid = 1'b1;
            mem_rdata  = mm[{la[16:4], bb}];
            beats++;
            last_act = cyc;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    mem_rvalid    = 1'b0;
    mem_req_ready = 1'b0;
    chk("resp_seen", 32'(done), 32'd1);
    chk("resp_hit", 32'(cpu_resp_hit), 32'(exp_hit));
    chk("resp_rdata", cpu_resp_rdata, we ? 32'd0 : mm[a]);
    last_rdata = cpu_resp_rdata;
    last_hit   = cpu_resp_hit;
    chk("mem_req_count", 32'(nreq), (!we && exp_hit) ? 32'd0 : 32'd1);
    if (nreq == 1) begin
      chk("mem_req_we", 32'(lw), 32'(we));
      chk("mem_req_addr", 32'(la), we ? 32'(a) : 32'({a[16:4], 4'h0}));
      if (we) chk("mem_req_wdata", ld, d);
    end
    if (!we && exp_hit) chk("hit_latency", 32'(cyc), 32'd2);
    else chk("resp_latency", 32'(cyc), 32'(last_act + 1));
    @(negedge clk);
    chk("resp_pulse", 32'(cpu_resp_valid), 32'd0);
    if (we) mm[a] = d;
    else if (!exp_hit) begin
      rv[idx] = 1'b1;
      rt[idx] = tg;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [9:0]  pool [4];
    logic [16:0] ra;
    int          w, b, nresp;
    logic [3:0]  bb;
    pool[0] = 10'h012; pool[1] = 10'h3FF;
    pool[2] = 10'h000; pool[3] = 10'h055;
    for (int i = 0; i < 131072; i++) mm[i] = i;
    for (int i = 0; i < 1024; i++) begin rv[i] = 0; rt[i] = '0; end
    rst = 1'b1;
    cpu_req_valid = 1'b0; cpu_req_we = 1'b0;
    cpu_req_addr = '0; cpu_req_wdata = '0;
    mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(cpu_req_ready), 32'd1);
    chk("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
    chk("rst_resp_rdata", cpu_resp_rdata, 32'd0);
    chk("rst_resp_hit", 32'(cpu_resp_hit), 32'd0);
    chk("rst_mreq_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mreq_we", 32'(mem_req_we), 32'd0);
    chk("rst_mreq_addr", 32'(mem_req_addr), 32'd0);
    chk("rst_mreq_wdata", mem_req_wdata, 32'd0);

    run_req(0, 17'h00123, 0, 0, 0);
    chk("lit_miss_rdata", last_rdata, 32'h123);
    chk("lit_miss_hit", 32'(last_hit), 32'd0);
    chk("lit_burst_addr", 32'(la), 32'h120);
    run_req(0, 17'h00123, 0, 0, 0);
    chk("lit_hit_rdata", last_rdata, 32'h123);
    chk("lit_hit_hit", 32'(last_hit), 32'd1);
    run_req(1, 17'h00125, 32'hDEADBEEF, 0, 0);
    chk("lit_st_addr", 32'(la), 32'h125);
    chk("lit_st_hit", 32'(last_hit), 32'd1);
    run_req(0, 17'h00125, 0, 0, 0);
    chk("lit_st_rd", last_rdata, 32'hDEADBEEF);
    run_req(0, 17'h04123, 0, 1, 30);
    chk("lit_evict_rd", last_rdata, 32'h4123);
    chk("lit_evict_hit", 32'(last_hit), 32'd0);
    run_req(0, 17'h00123, 0, 0, 0);
    chk("lit_remiss_hit", 32'(last_hit), 32'd0);
    run_req(1, 17'h1FFF0, 32'hCAFEF00D, 2, 0);
    chk("lit_stmiss_hit", 32'(last_hit), 32'd0);
    run_req(0, 17'h1FFF0, 0, 0, 0);
    chk("lit_stmiss_rd", last_rdata, 32'hCAFEF00D);

    // Reset in the middle of a gapped refill.
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0;
    cpu_req_addr = 17'h04123;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    w = 0;
    while (!mem_req_valid && w < 10) begin @(negedge clk); w++; end
    chk("rst_mreq_seen", 32'(mem_req_valid), 32'd1);
    repeat (5) @(negedge clk);
    chk("rst_mreq_held", 32'({mem_req_valid, mem_req_addr}),
        32'({1'b1, 17'h04120}));
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    b = 0; nresp = 0;
    for (int i = 0; i < 12 && b < 6; i++) begin
      mem_rvalid = 1'b0;
      if (i % 2 == 1) begin
        bb = 4'(b);
        mem_rvalid = 1'b1;
        mem_rdata  = mm[{13'h0412, bb}];
        b++;
      end
      @(negedge clk);
      if (cpu_resp_valid) nresp++;
    end
    rst = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) rst = 1'b0;
      bb = 4'(b);
      mem_rvalid = 1'b1;
      mem_rdata  = mm[{13'h0412, bb}];
      b++;
      @(negedge clk);
      if (cpu_resp_valid) nresp++;
    end
    mem_rvalid = 1'b0;
    chk("rst_no_resp", 32'(nresp), 32'd0);
    chk("rst_idle_ready", 32'(cpu_req_ready), 32'd1);
    chk("rst_idle_mreq", 32'(mem_req_valid), 32'd0);
    for (int i = 0; i < 1024; i++) rv[i] = 0;
    run_req(0, 17'h00123, 0, 0, 20);
    chk("lit_post_rst_hit", 32'(last_hit), 32'd0);
    chk("lit_post_rst_rd", last_rdata, 32'h123);

    for (int n = 0; n < 80; n++) begin
      ra = {3'($urandom_range(2)), pool[$urandom_range(3)],
            4'($urandom)};
      run_req(($urandom_range(99) < 30), ra, $urandom,
              int'($urandom_range(3)), 30);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Sequencing controller for the direct-mapped, 1024-line × 16-word × 32-bit cache. It accepts one CPU request at a time and owns the tag/valid state. It drives the line data RAM, refills missing lines from main memory as 16-beat bursts, and writes every store through to main memory. It sits between the CPU load/store port and the main-memory port, replacing ad-hoc same-cycle memory copies with a proper multi-cycle handshake.

## Interface
- ADDR_W, 17, word address width (tag 3 | index 10 | offset 4)
- DATA_W, 32, word width
- INDEX_W, 10, line index width
- OFFSET_W, 4, word-in-line offset width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req_valid  in  1  CPU request present
- cpu_req_ready  out  1  controller can accept; high only in IDLE
- cpu_req_we  in  1  1 = store, 0 = load
- cpu_req_addr  in  ADDR_W  word address
- cpu_req_wdata  in  DATA_W  store data
- cpu_resp_valid  out  1  one-cycle response pulse, no backpressure
- cpu_resp_rdata  out  DATA_W  load data (0 for stores)
- cpu_resp_hit  out  1  request hit in cache
- mem_req_valid  out  1  memory request present
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = word write, 0 = line read burst
- mem_req_addr  out  ADDR_W  line base (offset = 0) for reads, word address for writes
- mem_req_wdata  out  DATA_W  write data
- mem_rvalid  in  1  refill beat valid
- mem_rdata  in  DATA_W  refill beat data, words in order 0..15

## Operation
- Request accepted on cpu_req_valid & cpu_req_ready. addr, we and wdata are captured into registers; inputs are ignored thereafter.
- Hit = valid[index] & (tag_array[index] == addr tag).
- FSM states:
  - IDLE: ready = 1; on accept → LOOKUP.
  - LOOKUP, load hit: → RESP.
  - LOOKUP, load miss: → REFILL_REQ.
  - LOOKUP, store hit: write the word into the RAM, then → WRITE_MEM.
  - LOOKUP, store miss: no allocate, RAM untouched; → WRITE_MEM.
  - REFILL_REQ: mem_req_valid = 1, we = 0, addr = {tag, index, 4'b0}; on mem_req_ready → REFILL.
  - REFILL: on each mem_rvalid, write mem_rdata to RAM word beat_cnt and increment the 4-bit beat_cnt. When beat_cnt == captured offset, capture the data as the critical word. On the 16th beat (beat_cnt 15 → wraps to 0), set valid[index] = 1, tag_array[index] = tag, then → RESP.
  - WRITE_MEM: mem_req_valid = 1, we = 1, captured addr/wdata; on mem_req_ready → RESP.
  - RESP: cpu_resp_valid = 1 for exactly one cycle; → IDLE.
- Stores are write-through. Main memory is always current, so lines are never dirty and eviction needs no writeback.
- A refill overwrites the indexed line regardless of its previous tag.
- mem_rvalid outside REFILL is ignored.
- mem_req_* outputs are held stable while valid and not ready.

## Timing
- Reset values:
  - state = IDLE, all 1024 valid bits = 0, beat_cnt = 0.
  - cpu_req_ready = 1 (first cycle after reset deasserts).
  - cpu_resp_valid = 0, cpu_resp_rdata = 0, cpu_resp_hit = 0.
  - mem_req_valid = 0, mem_req_we = 0, mem_req_addr = 0, mem_req_wdata = 0.
- Load hit: accept at edge N, resp_valid high during cycle N+2. Latency 2, throughput 1 per 3 cycles.
- Load miss: 2 + request-wait cycles + 16 beats (any gaps) + 1 cycle to RESP.
- Store: 2 + memory-ready wait; earliest resp_valid is in cycle N+3.
- The data RAM has a synchronous read: the address is presented on accept and data is valid in LOOKUP.
- cpu_resp_hit reflects the LOOKUP compare and is held through RESP.
- rst asserted mid-refill or mid-write: abandon the operation, invalidate all lines, emit no response.

## Configuration
- CACHE_CTRL_STATS_EN defined:
  - adds outputs hit_count and miss_count, 32 bits each, reset to 0;
  - each increments once per request in LOOKUP and saturates at 0xFFFF_FFFF.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package cache_pkg:
  - width constants (ADDR_W, DATA_W, INDEX_W, OFFSET_W, TAG_W = 3);
  - state enum (IDLE, LOOKUP, REFILL_REQ, REFILL, WRITE_MEM, RESP);
  - tag/index/offset field-extract functions.
- Sub-module cache_data_ram: 16384 × DATA_W single-port synchronous RAM, addressed by {index, offset}, write enable, registered read. Tag/valid arrays stay in cache_ctrl.

## Test plan
- Reset, then load 0x00123 → miss. Memory sees a read burst at 0x00120; beats carry values 0x120+k; resp_rdata = 0x123, hit = 0.
- Repeat load 0x00123 → resp in cycle N+2, hit = 1, rdata = 0x123, no mem_req_valid.
- Store 0xDEADBEEF to 0x00125 (line present) → RAM updated and memory write at 0x00125. Next load 0x00125 → hit, 0xDEADBEEF.
- Load 0x04123 (same index, tag 1) → miss and refill replaces the line. Then load 0x00123 → miss again.
- Store to an invalid line 0x1FFF0 → memory write only, hit = 0. Following load 0x1FFF0 → miss, returns the stored value from memory.
- Hold mem_req_ready low 5 cycles and insert rvalid gaps; assert rst mid-refill → no resp_valid, then load 0x00123 → miss.
